// File: rtl/cpu_param.sv
// Parametrised Hack CPU core: A/D registers, ALU, PC and jump unit, with a hold
// input, registered write-latch outputs, and a WAIT state that stalls
// M-reading instructions until in_m is valid.
module cpu_param #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 15,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic [DATA_WIDTH-1:0] in_m,
    output logic [DATA_WIDTH-1:0] out_m,
    output logic                  write_m,
    output logic [ADDR_WIDTH-1:0] address_m,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] out_m_latch,
    output logic                  write_m_latch,
    output logic [ADDR_WIDTH-1:0] address_m_latch,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic [DATA_WIDTH-1:0] d_out
);

    localparam logic [0:0] StExec = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    // Counter start value; unused when READ_LATENCY is 0.
    localparam int unsigned CntInit = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

    logic [0:0]            state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] d_q, d_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] out_m_latch_q;
    logic                  write_m_latch_q;
    logic [ADDR_WIDTH-1:0] address_m_latch_q;

    // Instruction fields; bits DATA_WIDTH-2..13 of a C-instruction are ignored.
    logic is_c, a_bit, zx, nx, zy, ny, fn, no;
    logic dest_a, dest_d, dest_m, j_lt, j_eq, j_gt;

    assign is_c   = instruction[DATA_WIDTH-1];
    assign a_bit  = instruction[12];
    assign zx     = instruction[11];
    assign nx     = instruction[10];
    assign zy     = instruction[9];
    assign ny     = instruction[8];
    assign fn     = instruction[7];
    assign no     = instruction[6];
    assign dest_a = instruction[5];
    assign dest_d = instruction[4];
    assign dest_m = instruction[3];
    assign j_lt   = instruction[2];
    assign j_eq   = instruction[1];
    assign j_gt   = instruction[0];

    logic [DATA_WIDTH-1:0] alu_x, alu_y, alu_out;
    logic                  zr, ng;

    // Standard Hack ALU: x is D, y is M or A depending on the a bit.
    always_comb begin
        alu_x = zx ? '0 : d_q;
        alu_x = nx ? ~alu_x : alu_x;
        alu_y = a_bit ? in_m : a_q;
        alu_y = zy ? '0 : alu_y;
        alu_y = ny ? ~alu_y : alu_y;
        alu_out = fn ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_out = no ? ~alu_out : alu_out;
    end

    assign zr = (alu_out == '0);
    assign ng = alu_out[DATA_WIDTH-1];

    logic stall_req, exec_en, enter_wait, jump;

    // An M-reading C-instruction must wait for in_m when there is read latency.
    assign stall_req  = (READ_LATENCY != 0) && is_c && a_bit;
    assign exec_en    = !hold && (((state_q == StExec) && !stall_req) ||
                                  ((state_q == StWait) && (cnt_q == 3'd0)));
    assign enter_wait = !hold && (state_q == StExec) && stall_req;
    assign jump       = is_c && ((j_lt && ng) || (j_eq && zr) || (j_gt && !ng && !zr));

    assign out_m     = alu_out;
    assign write_m   = is_c && dest_m && !hold && (state_q == StExec) && !stall_req;
    assign address_m = a_q[ADDR_WIDTH-1:0];

    // Next architectural state and WAIT sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        d_d     = d_q;
        pc_d    = pc_q;
        if (enter_wait) begin
            state_d = StWait;
            cnt_d   = 3'(CntInit);
        end else if (!hold && (state_q == StWait) && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end else if (exec_en) begin
            state_d = StExec;
            if (!is_c) begin
                a_d = {1'b0, instruction[DATA_WIDTH-2:0]};
            end else begin
                if (dest_a) a_d = alu_out;
                if (dest_d) d_d = alu_out;
            end
            // Jump target is the A value before this edge's update.
            pc_d = jump ? a_q[ADDR_WIDTH-1:0] : pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // State registers; reset overrides hold and abandons any pending WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= StExec;
            cnt_q             <= 3'd0;
            a_q               <= '0;
            d_q               <= '0;
            pc_q              <= '0;
            out_m_latch_q     <= '0;
            write_m_latch_q   <= 1'b0;
            address_m_latch_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
            if (exec_en) begin
                out_m_latch_q     <= out_m;
                write_m_latch_q   <= write_m;
                address_m_latch_q <= address_m;
            end
        end
    end

    assign pc              = pc_q;
    assign out_m_latch     = out_m_latch_q;
    assign write_m_latch   = write_m_latch_q;
    assign address_m_latch = address_m_latch_q;
    assign busy            = (state_q == StWait);
    assign a_out           = a_q;
    assign d_out           = d_q;

endmodule

// File: tb/tb_cpu_param.sv
// Directed bench for cpu_param: default core, READ_LATENCY=2 core, and a
// 24/20-bit wide core, each driven by hand-encoded Hack programs.
module tb_cpu_param;

    localparam logic [6:0] CZero = 7'b0101010;
    localparam logic [6:0] COne  = 7'b0111111;
    localparam logic [6:0] CNeg1 = 7'b0111010;
    localparam logic [6:0] CD    = 7'b0001100;
    localparam logic [6:0] CA    = 7'b0110000;
    localparam logic [6:0] CM    = 7'b1110000;
    localparam logic [6:0] CDp1  = 7'b0011111;
    localparam logic [6:0] CAp1  = 7'b0110111;
    localparam logic [6:0] CDpA  = 7'b0000010;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Default-parameter core
    logic        reset0 = 1'b1, hold0 = 1'b0;
    logic [15:0] instr0 = '0, in_m0 = '0;
    logic [15:0] out_m0, out_m_latch0, a0, d0;
    logic        write_m0, write_m_latch0, busy0;
    logic [14:0] address_m0, pc0, address_m_latch0;

    cpu_param dut0 (
        .clock(clock), .reset(reset0), .hold(hold0), .instruction(instr0), .in_m(in_m0),
        .out_m(out_m0), .write_m(write_m0), .address_m(address_m0), .pc(pc0),
        .out_m_latch(out_m_latch0), .write_m_latch(write_m_latch0),
        .address_m_latch(address_m_latch0), .busy(busy0), .a_out(a0), .d_out(d0)
    );

    // Read-latency core
    logic        reset1 = 1'b1, hold1 = 1'b0;
    logic [15:0] instr1 = '0, in_m1 = '0;
    logic [15:0] out_m1, out_m_latch1, a1, d1;
    logic        write_m1, write_m_latch1, busy1;
    logic [14:0] address_m1, pc1, address_m_latch1;

    cpu_param #(.READ_LATENCY(2)) dut1 (
        .clock(clock), .reset(reset1), .hold(hold1), .instruction(instr1), .in_m(in_m1),
        .out_m(out_m1), .write_m(write_m1), .address_m(address_m1), .pc(pc1),
        .out_m_latch(out_m_latch1), .write_m_latch(write_m_latch1),
        .address_m_latch(address_m_latch1), .busy(busy1), .a_out(a1), .d_out(d1)
    );

    // Wide core
    logic        reset2 = 1'b1, hold2 = 1'b0;
    logic [23:0] instr2 = '0, in_m2 = '0;
    logic [23:0] out_m2, out_m_latch2, a2, d2;
    logic        write_m2, write_m_latch2, busy2;
    logic [19:0] address_m2, pc2, address_m_latch2;

    cpu_param #(.DATA_WIDTH(24), .ADDR_WIDTH(20)) dut2 (
        .clock(clock), .reset(reset2), .hold(hold2), .instruction(instr2), .in_m(in_m2),
        .out_m(out_m2), .write_m(write_m2), .address_m(address_m2), .pc(pc2),
        .out_m_latch(out_m_latch2), .write_m_latch(write_m_latch2),
        .address_m_latch(address_m_latch2), .busy(busy2), .a_out(a2), .d_out(d2)
    );

    function automatic logic [15:0] ci(input logic [6:0] comp, input logic [2:0] dest,
                                       input logic [2:0] jmp);
        return {3'b111, comp, dest, jmp};
    endfunction

    function automatic logic [23:0] ci24(input logic [6:0] comp, input logic [2:0] dest,
                                         input logic [2:0] jmp);
        return {1'b1, 10'b0, comp, dest, jmp};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        // ---------------- default core: reset / hold ----------------
        tick();
        check("rst_pc", 32'(pc0), 32'd0);
        check("rst_a", 32'(a0), 32'd0);
        check("rst_d", 32'(d0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_wlatch", 32'(write_m_latch0), 32'd0);
        reset0 = 1'b0;
        tick();
        check("first_pc", 32'(pc0), 32'd1);
        instr0 = ci(CD, 3'b001, 3'b000);  // M=D, must be suppressed by hold
        hold0 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check("hold_wm", 32'(write_m0), 32'd0);
        end
        check("hold_pc", 32'(pc0), 32'd1);
        hold0 = 1'b0;

        // ---------------- datapath ----------------
        instr0 = 16'd123;               tick();
        instr0 = ci(CA, 3'b010, 3'b000); tick();
        instr0 = ci(CDpA, 3'b010, 3'b000); tick();
        instr0 = ci(CD, 3'b100, 3'b000); tick();
        check("dp_a", 32'(a0), 32'd246);
        check("dp_d", 32'(d0), 32'd246);
        check("dp_addr", 32'(address_m0), 32'd246);
        check("dp_pc", 32'(pc0), 32'd5);
        instr0 = ci(CD, 3'b001, 3'b000); #1;
        check("mw_wm", 32'(write_m0), 32'd1);
        check("mw_outm", 32'(out_m0), 32'd246);
        tick();
        instr0 = ci(CAp1, 3'b100, 3'b000); #1;
        check("ainc_wm", 32'(write_m0), 32'd0);
        tick();
        check("ainc_addr", 32'(address_m0), 32'd247);
        check("ainc_pc", 32'(pc0), 32'd7);

        // ---------------- jumps ----------------
        instr0 = 16'd44;                 tick();
        instr0 = ci(COne, 3'b010, 3'b000); tick();
        instr0 = ci(CD, 3'b000, 3'b010); tick();
        check("jeq_nt", 32'(pc0), 32'd10);
        instr0 = ci(CD, 3'b000, 3'b100); tick();
        check("jlt_nt", 32'(pc0), 32'd11);
        instr0 = ci(CD, 3'b000, 3'b001); tick();
        check("jgt_t", 32'(pc0), 32'd44);
        instr0 = 16'd4444;                tick();
        instr0 = ci(CNeg1, 3'b010, 3'b000); tick();
        check("neg1_d", 32'(d0), 32'h0000ffff);
        instr0 = ci(CD, 3'b000, 3'b011); tick();
        check("jge_nt", 32'(pc0), 32'd47);
        instr0 = ci(CD, 3'b000, 3'b110); tick();
        check("jle_t", 32'(pc0), 32'd4444);
        instr0 = 16'd4;                   tick();
        instr0 = ci(CZero, 3'b000, 3'b111); tick();
        check("jmp", 32'(pc0), 32'd4);

        // ---------------- latches ----------------
        instr0 = 16'd123;                 tick(); hold0 = 1'b1; tick(); hold0 = 1'b0;
        instr0 = ci(CA, 3'b010, 3'b000);  tick(); hold0 = 1'b1; tick(); hold0 = 1'b0;
        instr0 = 16'd456;                 tick(); hold0 = 1'b1; tick(); hold0 = 1'b0;
        instr0 = ci(CDp1, 3'b111, 3'b000); tick(); hold0 = 1'b1; tick();
        for (int i = 0; i < 100; i++) tick();
        check("lat_wm", 32'(write_m0), 32'd0);
        check("lat_wml", 32'(write_m_latch0), 32'd1);
        check("lat_addrl", 32'(address_m_latch0), 32'd456);
        check("lat_outl", 32'(out_m_latch0), 32'd124);
        check("lat_addr", 32'(address_m0), 32'd124);
        check("lat_outm", 32'(out_m0), 32'd125);

        // ---------------- read stall, READ_LATENCY=2 ----------------
        tick();
        reset1 = 1'b0;
        in_m1  = 16'h0005;
        instr1 = 16'd10;                  tick();
        check("rl_pc0", 32'(pc1), 32'd1);
        instr1 = ci(CM, 3'b010, 3'b000);  tick();
        check("rl_busy1", 32'(busy1), 32'd1);
        check("rl_pc1", 32'(pc1), 32'd1);
        check("rl_d1", 32'(d1), 32'd0);
        tick();
        check("rl_busy2", 32'(busy1), 32'd1);
        check("rl_pc2", 32'(pc1), 32'd1);
        check("rl_d2", 32'(d1), 32'd0);
        tick();
        check("rl_busy3", 32'(busy1), 32'd0);
        check("rl_d3", 32'(d1), 32'd5);
        check("rl_pc3", 32'(pc1), 32'd2);
        // Hold for three edges mid-WAIT
        in_m1 = 16'h0007;
        tick();
        hold1 = 1'b1;
        tick(); tick(); tick();
        check("rlh_busy", 32'(busy1), 32'd1);
        check("rlh_pc", 32'(pc1), 32'd2);
        hold1 = 1'b0;
        tick();
        check("rlh_busy5", 32'(busy1), 32'd1);
        check("rlh_d5", 32'(d1), 32'd5);
        tick();
        check("rlh_busy6", 32'(busy1), 32'd0);
        check("rlh_d6", 32'(d1), 32'd7);
        check("rlh_pc6", 32'(pc1), 32'd3);
        // DM=M: stalls, so never strobes; then reset mid-WAIT
        instr1 = ci(CM, 3'b011, 3'b000); #1;
        check("rlw_wm0", 32'(write_m1), 32'd0);
        tick();
        check("rlw_busy", 32'(busy1), 32'd1);
        check("rlw_wm1", 32'(write_m1), 32'd0);
        reset1 = 1'b1;
        tick();
        check("rlr_busy", 32'(busy1), 32'd0);
        check("rlr_pc", 32'(pc1), 32'd0);
        check("rlr_d", 32'(d1), 32'd0);

        // ---------------- wide core ----------------
        reset2 = 1'b0;
        instr2 = 24'h3FFFFF;                 tick();
        check("w_a", 32'(a2), 32'h003FFFFF);
        check("w_addr", 32'(address_m2), 32'h000FFFFF);
        instr2 = ci24(CA, 3'b010, 3'b000);   tick();
        instr2 = ci24(CDp1, 3'b010, 3'b000); tick();
        check("w_d", 32'(d2), 32'h00400000);
        instr2 = ci24(CZero, 3'b000, 3'b111); tick();
        check("w_jmp", 32'(pc2), 32'h000FFFFF);
        instr2 = ci24(CD, 3'b010, 3'b000);   tick();
        check("w_wrap", 32'(pc2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
